// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and widths for the A2D converter arbiter
package a2d_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int A2D_CHNL_W = 3;
   localparam int A2D_RES_W  = 12;

endpackage

// File: rtl/a2d_arbiter_if.sv
// a2d_arbiter_if: requester and converter signals shared by the arbiter and its users
interface a2d_arbiter_if
   import a2d_pkg::*;
#(
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0]            req;
   logic [A2D_CHNL_W*NUM_REQ-1:0] req_chnnl;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rsp_vld;
   logic [A2D_RES_W-1:0]          rsp_data;
   logic                          rsp_err;
   logic                          busy;
   logic                          strt_cnv;
   logic [A2D_CHNL_W-1:0]         chnnl;
   logic                          cnv_cmplt;
   logic [A2D_RES_W-1:0]          res;

   modport slave (
      input  req, req_chnnl, cnv_cmplt, res,
      output gnt, rsp_vld, rsp_data, rsp_err, busy, strt_cnv, chnnl
   );

   modport master (
      output req, req_chnnl, cnv_cmplt, res,
      input  gnt, rsp_vld, rsp_data, rsp_err, busy, strt_cnv, chnnl
   );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after the pointer, wrapping, as one-hot plus index
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IW-1:0]      win_idx,
   output logic               any
);

   logic [IW-1:0] j;

   // scan from farthest to nearest so the last hit is the closest one at/after ptr
   always_comb begin
      win_idx = '0;
      any     = 1'b0;
      j       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = IW'((int'(ptr) + k) % NUM_REQ);
         if (req[j]) begin
            win_idx = j;
            any     = 1'b1;
         end
      end
      win_oh = any ? (NUM_REQ'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin sharing of one A2D converter with settling gap and watchdog
module a2d_arbiter
   import a2d_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic         clk,
   input logic         rst_n,
   a2d_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam int GW = $clog2(GAP_CYCLES + 2);

   arb_state_t            state;
   logic [NUM_REQ-1:0]    win_oh;
   logic [IW-1:0]         win_idx;
   logic [A2D_CHNL_W-1:0] chnnl_q;
   logic [IW-1:0]         ptr;
   logic [GW-1:0]         gap;
   logic [WW-1:0]         wd;
   logic                  err_q;
   logic [A2D_RES_W-1:0]  data_q;

   logic [NUM_REQ-1:0]    pick_oh;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;
   logic [A2D_CHNL_W-1:0] pick_ch;

   rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req     (bus.req),
      .ptr     (ptr),
      .win_oh  (pick_oh),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // channel of the requester that would win this cycle
   always_comb begin
      pick_ch = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_idx == IW'(i)) pick_ch = bus.req_chnnl[A2D_CHNL_W*i +: A2D_CHNL_W];
   end

   // grant, start, wait for completion or watchdog, then respond and enforce the gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         win_oh  <= '0;
         win_idx <= '0;
         chnnl_q <= '0;
         ptr     <= '0;
         gap     <= '0;
         wd      <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gap != '0) gap <= gap - GW'(1);
               else if (pick_any) begin
                  win_oh  <= pick_oh;
                  win_idx <= pick_idx;
                  chnnl_q <= pick_ch;
                  state   <= START;
               end
            end
            START: begin
               wd    <= '0;
               err_q <= 1'b0;
               state <= WAIT;
            end
            WAIT: begin
               if (bus.cnv_cmplt) begin
                  data_q <= bus.res;
                  state  <= DONE;
               end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                  data_q <= '1;
                  err_q  <= 1'b1;
                  state  <= DONE;
               end else wd <= wd + WW'(1);
            end
            default: begin
               ptr   <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
               gap   <= GW'(GAP_CYCLES);
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt      = (state == IDLE) ? '0 : win_oh;
   assign bus.rsp_vld  = (state == DONE) ? win_oh : '0;
   assign bus.rsp_err  = (state == DONE) && err_q;
   assign bus.rsp_data = data_q;
   assign bus.strt_cnv = (state == START);
   assign bus.chnnl    = chnnl_q;
   assign bus.busy     = (state != IDLE) || (gap != '0);

endmodule
